// File: rtl/csr_bus_ctrl.sv
// Avalon-MM front end for the CSR bank: decodes host accesses into register_csr strobes.
// The hardware bit-write port and its fairness flag are built only with CSR_BUS_HW_PORT_EN.
module csr_bus_ctrl #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS) + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           avs_address,
   input  logic                        avs_write,
   input  logic                        avs_read,
   input  logic [WIDTH-1:0]            avs_writedata,
   output logic                        avs_waitrequest,
   output logic [WIDTH-1:0]            avs_readdata,
   output logic                        avs_readdatavalid,
   input  logic                        hw_bit_req,
   input  logic [$clog2(NUM_REGS)-1:0] hw_bit_reg,
   input  logic [$clog2(WIDTH)-1:0]    hw_bit_addr,
   input  logic                        hw_bit_val,
   output logic                        hw_bit_ack,
   input  logic [NUM_REGS*WIDTH-1:0]   csr_q_all,
   output logic [WIDTH-1:0]            csr_d_all,
   output logic                        csr_d_bit,
   output logic [$clog2(WIDTH)-1:0]    csr_bit_address,
   output logic [NUM_REGS-1:0]         csr_load_all_n,
   output logic [NUM_REGS-1:0]         csr_load_bit_n
);

   // state   | meaning
   // S_IDLE  | waiting; arbitrates bus write > bus read > hw bit write (hw first if pending)
   // S_BUS_WR| host write accepted, one load strobe low
   // S_RD    | host read accepted, read data captured at the end of this cycle
   // S_RESP  | readdatavalid high
   // S_HW_WR | hw bit write strobe and ack

   localparam int LW = $clog2(NUM_REGS);
   localparam int BW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUS_WR,
      S_RD,
`ifdef CSR_BUS_HW_PORT_EN
      S_HW_WR,
`endif
      S_RESP
   } state_t;

   state_t              r_state;
   logic                r_waitrequest;
   logic                r_readdatavalid;
   logic [WIDTH-1:0]    r_readdata;
   logic [WIDTH-1:0]    r_d_all;
   logic                r_d_bit;
   logic [BW-1:0]       r_bit_address;
   logic [NUM_REGS-1:0] r_load_all_n;
   logic [NUM_REGS-1:0] r_load_bit_n;
   logic [LW-1:0]       r_idx;
   logic                r_idx_ok;

   logic [LW-1:0]       w_idx;
   logic                w_in_range;
   logic                w_bit_op;
   logic [NUM_REGS-1:0] w_sel;
   logic                w_hw_go;

   assign w_idx    = avs_address[LW-1:0];
   assign w_bit_op = avs_address[ADDR_W-1];
   assign w_sel    = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_idx;

   // A widened address field lets the host hit indices past the bank; those are dropped.
   if (ADDR_W - 1 > LW) begin : g_range
      assign w_in_range = (avs_address[ADDR_W-2:LW] == '0);
   end else begin : g_norange
      assign w_in_range = 1'b1;
   end

`ifdef CSR_BUS_HW_PORT_EN
   logic                r_hw_pending;
   logic                r_hw_bit_ack;
   logic [NUM_REGS-1:0] w_hw_sel;

   assign w_hw_sel   = {{(NUM_REGS-1){1'b0}}, 1'b1} << hw_bit_reg;
   assign w_hw_go    = hw_bit_req & (r_hw_pending | ~(avs_write | avs_read));
   assign hw_bit_ack = r_hw_bit_ack;
`else
   logic w_unused_hw;

   assign w_unused_hw = ^{hw_bit_req, hw_bit_reg, hw_bit_addr, hw_bit_val};
   assign w_hw_go     = 1'b0;
   assign hw_bit_ack  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_waitrequest   <= 1'b1;
         r_readdatavalid <= 1'b0;
         r_readdata      <= '0;
         r_d_all         <= '0;
         r_d_bit         <= 1'b0;
         r_bit_address   <= '0;
         r_load_all_n    <= '1;
         r_load_bit_n    <= '1;
         r_idx           <= '0;
         r_idx_ok        <= 1'b0;
`ifdef CSR_BUS_HW_PORT_EN
         r_hw_pending    <= 1'b0;
         r_hw_bit_ack    <= 1'b0;
`endif
      end else begin
         r_waitrequest   <= 1'b1;
         r_readdatavalid <= 1'b0;
         r_load_all_n    <= '1;
         r_load_bit_n    <= '1;
`ifdef CSR_BUS_HW_PORT_EN
         r_hw_bit_ack    <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (avs_write && !w_hw_go) begin
                  r_state       <= S_BUS_WR;
                  r_waitrequest <= 1'b0;
                  if (w_in_range) begin
                     if (w_bit_op) begin
                        r_load_bit_n  <= ~w_sel;
                        r_d_bit       <= avs_writedata[WIDTH-1];
                        r_bit_address <= avs_writedata[BW-1:0];
                     end else begin
                        r_load_all_n  <= ~w_sel;
                        r_d_all       <= avs_writedata;
                     end
                  end
               end else if (avs_read && !w_hw_go) begin
                  r_state       <= S_RD;
                  r_waitrequest <= 1'b0;
                  r_idx         <= w_idx;
                  r_idx_ok      <= w_in_range;
               end
`ifdef CSR_BUS_HW_PORT_EN
               if (w_hw_go) begin
                  r_state       <= S_HW_WR;
                  r_hw_bit_ack  <= 1'b1;
                  r_hw_pending  <= 1'b0;
                  r_load_bit_n  <= ~w_hw_sel;
                  r_d_bit       <= hw_bit_val;
                  r_bit_address <= hw_bit_addr;
               end else if (hw_bit_req) begin
                  r_hw_pending  <= 1'b1;
               end
`endif
            end
            S_BUS_WR: r_state <= S_IDLE;
            S_RD: begin
               r_state         <= S_RESP;
               r_readdatavalid <= 1'b1;
               r_readdata      <= r_idx_ok ? csr_q_all[int'(r_idx)*WIDTH +: WIDTH] : '0;
            end
            S_RESP: r_state <= S_IDLE;
`ifdef CSR_BUS_HW_PORT_EN
            S_HW_WR: r_state <= S_IDLE;
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign avs_waitrequest   = r_waitrequest;
   assign avs_readdatavalid = r_readdatavalid;
   assign avs_readdata      = r_readdata;
   assign csr_d_all         = r_d_all;
   assign csr_d_bit         = r_d_bit;
   assign csr_bit_address   = r_bit_address;
   assign csr_load_all_n    = r_load_all_n;
   assign csr_load_bit_n    = r_load_bit_n;

endmodule

// File: tb/tb_csr_bus_ctrl.sv
// Self-checking bench for csr_bus_ctrl with a behavioural CSR bank and a register-level scoreboard.
// Address field widened by one bit so out-of-range indices (8..15) are reachable.
module tb_csr_bus_ctrl;
   localparam int WIDTH    = 32;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 5;
   localparam int BW       = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [ADDR_W-1:0]   avs_address;
   logic                avs_write, avs_read;
   logic [WIDTH-1:0]    avs_writedata;
   logic                avs_waitrequest;
   logic [WIDTH-1:0]    avs_readdata;
   logic                avs_readdatavalid;
   logic                hw_bit_req;
   logic [2:0]          hw_bit_reg;
   logic [BW-1:0]       hw_bit_addr;
   logic                hw_bit_val;
   logic                hw_bit_ack;
   logic [NUM_REGS*WIDTH-1:0] csr_q_all;
   logic [WIDTH-1:0]    csr_d_all;
   logic                csr_d_bit;
   logic [BW-1:0]       csr_bit_address;
   logic [NUM_REGS-1:0] csr_load_all_n, csr_load_bit_n;

   int n_vec = 0;
   int n_err = 0;

   logic [WIDTH-1:0] exp_regs [NUM_REGS];
   logic [WIDTH-1:0] bank [NUM_REGS];
   logic             bank_clr;

   csr_bus_ctrl #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
      .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
      .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
      .hw_bit_req(hw_bit_req), .hw_bit_reg(hw_bit_reg), .hw_bit_addr(hw_bit_addr),
      .hw_bit_val(hw_bit_val), .hw_bit_ack(hw_bit_ack),
      .csr_q_all(csr_q_all), .csr_d_all(csr_d_all), .csr_d_bit(csr_d_bit),
      .csr_bit_address(csr_bit_address), .csr_load_all_n(csr_load_all_n),
      .csr_load_bit_n(csr_load_bit_n)
   );

   // Behavioural register_csr bank driven by the DUT strobes.
   always @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bank_clr) bank[i] <= '0;
         else if (!csr_load_all_n[i]) bank[i] <= csr_d_all;
         else if (!csr_load_bit_n[i]) bank[i][csr_bit_address] <= csr_d_bit;
      end
   end

   always_comb begin
      csr_q_all = '0;
      for (int i = 0; i < NUM_REGS; i++) csr_q_all[i*WIDTH +: WIDTH] = bank[i];
   end

   function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      int idx;
      idx = int'(a[ADDR_W-2:0]);
      if (idx < NUM_REGS) begin
         if (a[ADDR_W-1]) exp_regs[idx][d[BW-1:0]] = d[WIDTH-1];
         else exp_regs[idx] = d;
      end
   endfunction

   function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_W-1:0] a);
      int idx;
      idx = int'(a[ADDR_W-2:0]);
      if (idx < NUM_REGS) return exp_regs[idx];
      return '0;
   endfunction

   function automatic logic [NUM_REGS-1:0] exp_strobe(input logic [ADDR_W-1:0] a, input logic bitop);
      int idx;
      idx = int'(a[ADDR_W-2:0]);
      if (idx < NUM_REGS && a[ADDR_W-1] == bitop) return ~(8'b1 << idx);
      return 8'hFF;
   endfunction

   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      int lat;
      @(posedge clk); #1;
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      lat = 0;
      @(negedge clk);
      while (avs_waitrequest === 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      n_vec++;
      if (lat !== 1) begin n_err++; $display("FAIL wr_accept addr=%h got latency %0d want 1", a, lat); end
      if (avs_waitrequest !== 1'b0) begin avs_write = 1'b0; return; end
      n_vec++;
      if (csr_load_all_n !== exp_strobe(a, 1'b0) || csr_load_bit_n !== exp_strobe(a, 1'b1)) begin
         n_err++;
         $display("FAIL wr_strobe addr=%h got all_n=%h bit_n=%h want all_n=%h bit_n=%h",
                  a, csr_load_all_n, csr_load_bit_n, exp_strobe(a, 1'b0), exp_strobe(a, 1'b1));
      end
      if (int'(a[ADDR_W-2:0]) < NUM_REGS) begin
         n_vec++;
         if (a[ADDR_W-1] && (csr_bit_address !== d[BW-1:0] || csr_d_bit !== d[WIDTH-1])) begin
            n_err++;
            $display("FAIL wr_bitdata got addr=%0d val=%b want addr=%0d val=%b",
                     csr_bit_address, csr_d_bit, d[BW-1:0], d[WIDTH-1]);
         end else if (!a[ADDR_W-1] && csr_d_all !== d) begin
            n_err++;
            $display("FAIL wr_data got %h want %h", csr_d_all, d);
         end
      end
      model_write(a, d);
      @(posedge clk); #1;
      avs_write = 1'b0;
      @(negedge clk);
      n_vec++;
      if (csr_load_all_n !== 8'hFF || csr_load_bit_n !== 8'hFF) begin
         n_err++;
         $display("FAIL wr_oneshot got all_n=%h bit_n=%h want ff ff", csr_load_all_n, csr_load_bit_n);
      end
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a);
      int lat;
      logic [WIDTH-1:0] e;
      e = exp_read(a);
      @(posedge clk); #1;
      avs_address = a; avs_read = 1'b1;
      lat = 0;
      @(negedge clk);
      while (avs_waitrequest === 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      n_vec++;
      if (lat !== 1) begin n_err++; $display("FAIL rd_accept addr=%h got latency %0d want 1", a, lat); end
      if (avs_waitrequest !== 1'b0) begin avs_read = 1'b0; return; end
      @(posedge clk); #1;
      avs_read = 1'b0;
      @(negedge clk);
      n_vec++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== e) begin
         n_err++;
         $display("FAIL rd_data addr=%h got rdv=%b data=%h want rdv=1 data=%h",
                  a, avs_readdatavalid, avs_readdata, e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bank_clr = 1'b1;
      avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
      hw_bit_req = 1'b0; hw_bit_reg = '0; hw_bit_addr = '0; hw_bit_val = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({avs_waitrequest, avs_readdatavalid, hw_bit_ack, csr_d_bit} !== 4'b1000) begin
         n_err++;
         $display("FAIL rst_ctl got wr=%b rdv=%b ack=%b dbit=%b want 1 0 0 0",
                  avs_waitrequest, avs_readdatavalid, hw_bit_ack, csr_d_bit);
      end
      n_vec++;
      if (csr_load_all_n !== 8'hFF || csr_load_bit_n !== 8'hFF) begin
         n_err++; $display("FAIL rst_strobe got %h %h want ff ff", csr_load_all_n, csr_load_bit_n);
      end
      n_vec++;
      if (avs_readdata !== '0 || csr_d_all !== '0 || csr_bit_address !== '0) begin
         n_err++;
         $display("FAIL rst_data got rd=%h dall=%h baddr=%0d want 0 0 0", avs_readdata, csr_d_all, csr_bit_address);
      end
      @(posedge clk); #1;
      reset = 1'b1; bank_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_whole_write();
      bus_write(5'h03, 32'hDEADBEEF);
      bus_read(5'h03);
      @(negedge clk);
      n_vec++;
      if (avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rdv_oneshot got 1 want 0"); end
   endtask

   task automatic test_bit_op();
      bus_write(5'h11, 32'h80000005);
      bus_read(5'h01);
      n_vec++;
      if (avs_readdata[5] !== 1'b1) begin n_err++; $display("FAIL bitop_readback got %b want 1", avs_readdata[5]); end
      bus_write(5'h11, 32'h00000005);
      bus_read(5'h11);
   endtask

   task automatic test_out_of_range();
      bus_write(5'h0D, 32'h12345678);
      bus_write(5'h1A, 32'h8000001F);
      bus_read(5'h0D);
      bus_read(5'h1A);
      for (int i = 0; i < NUM_REGS; i++) bus_read(5'(i));
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         logic [ADDR_W-1:0] a;
         logic [WIDTH-1:0]  d;
         a = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
         d = $urandom;
         if ($urandom_range(0, 1) == 0) bus_write(a, d);
         else bus_read(a);
      end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] a;
      logic [WIDTH-1:0]  d;
      int cyc, prev, guard;
      cyc = 0; prev = 0;
      @(posedge clk); #1;
      a = 5'h04; d = $urandom;
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      for (int k = 0; k < 6; k++) begin
         guard = 0;
         @(negedge clk); cyc++;
         while (avs_waitrequest === 1'b1 && guard < 10) begin @(negedge clk); cyc++; guard++; end
         if (guard >= 10) begin
            n_vec++; n_err++; $display("FAIL b2b_timeout write %0d never accepted", k);
            break;
         end
         if (k > 0) begin
            n_vec++;
            if (cyc - prev !== 2) begin n_err++; $display("FAIL b2b_spacing got %0d want 2", cyc - prev); end
         end
         prev = cyc;
         n_vec++;
         if (csr_load_all_n !== exp_strobe(a, 1'b0)) begin
            n_err++; $display("FAIL b2b_strobe got %h want %h", csr_load_all_n, exp_strobe(a, 1'b0));
         end
         model_write(a, d);
         @(posedge clk); #1;
         a = 5'(4 + ((k + 1) % 4)); d = $urandom;
         avs_address = a; avs_writedata = d;
      end
      avs_write = 1'b0;
      for (int i = 4; i < 8; i++) bus_read(5'(i));
   endtask

   task automatic test_write_read_together();
      logic [WIDTH-1:0] d;
      int guard;
      d = $urandom;
      @(posedge clk); #1;
      avs_address = 5'h06; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b1;
      guard = 0;
      @(negedge clk);
      while (avs_waitrequest === 1'b1 && guard < 10) begin @(negedge clk); guard++; end
      n_vec++;
      if (guard !== 1 || csr_load_all_n !== 8'hBF) begin
         n_err++; $display("FAIL wrrd_write got lat=%0d all_n=%h want 1 bf", guard, csr_load_all_n);
      end
      model_write(5'h06, d);
      @(posedge clk); #1;
      avs_write = 1'b0;
      guard = 0;
      @(negedge clk);
      while (avs_waitrequest === 1'b1 && guard < 10) begin @(negedge clk); guard++; end
      n_vec++;
      if (guard !== 1 || csr_load_all_n !== 8'hFF || csr_load_bit_n !== 8'hFF) begin
         n_err++;
         $display("FAIL wrrd_read_accept got wait=%0d all_n=%h bit_n=%h want 1 ff ff", guard, csr_load_all_n, csr_load_bit_n);
      end
      @(posedge clk); #1;
      avs_read = 1'b0;
      @(negedge clk);
      n_vec++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== d) begin
         n_err++; $display("FAIL wrrd_data got rdv=%b data=%h want 1 %h", avs_readdatavalid, avs_readdata, d);
      end
   endtask

   task automatic test_hw_port();
      logic [ADDR_W-1:0] a;
      logic [WIDTH-1:0]  d;
      int n_ack, lat;
      logic ack_s, acc_s;
`ifdef CSR_BUS_HW_PORT_EN
      logic [BW-1:0] b;
      b = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      hw_bit_req = 1'b1; hw_bit_reg = 3'd3; hw_bit_addr = b; hw_bit_val = 1'b1;
      lat = 0;
      @(negedge clk);
      while (hw_bit_ack !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
      n_vec++;
      if (lat !== 1 || csr_load_bit_n !== 8'hF7 || csr_bit_address !== b || csr_d_bit !== 1'b1) begin
         n_err++;
         $display("FAIL hw_min got lat=%0d bit_n=%h baddr=%0d val=%b want 1 f7 %0d 1", lat, csr_load_bit_n, csr_bit_address, csr_d_bit, b);
      end
      exp_regs[3][b] = 1'b1;
      @(posedge clk); #1;
      hw_bit_req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (hw_bit_ack !== 1'b0) begin n_err++; $display("FAIL hw_ack_oneshot got 1 want 0"); end
      bus_read(5'h03);
`endif
      n_ack = 0; lat = -1;
      @(posedge clk); #1;
      hw_bit_req = 1'b1; hw_bit_reg = 3'd2; hw_bit_addr = '0; hw_bit_val = 1'b1;
      a = 5'(4 + $urandom_range(0, 3)); d = $urandom;
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ack_s = hw_bit_ack;
         acc_s = !avs_waitrequest;
         if (ack_s === 1'b1) begin
            n_ack++;
            if (lat < 0) lat = c;
            n_vec++;
            if (csr_load_bit_n !== 8'hFB || csr_bit_address !== '0 || csr_d_bit !== 1'b1) begin
               n_err++;
               $display("FAIL hw_strobe got bit_n=%h baddr=%0d val=%b want fb 0 1", csr_load_bit_n, csr_bit_address, csr_d_bit);
            end
            exp_regs[2][0] = 1'b1;
         end
         if (acc_s) model_write(a, d);
         @(posedge clk); #1;
         if (ack_s === 1'b1) hw_bit_req = 1'b0;
         if (acc_s && c >= 10) break;
         if (acc_s) begin
            a = 5'(4 + $urandom_range(0, 3)); d = $urandom;
            avs_address = a; avs_writedata = d;
         end
      end
      avs_write = 1'b0; hw_bit_req = 1'b0;
`ifdef CSR_BUS_HW_PORT_EN
      n_vec++;
      if (n_ack !== 1 || lat < 1 || lat > 4) begin
         n_err++; $display("FAIL hw_fair got acks=%0d latency=%0d want 1 ack within 1..4", n_ack, lat);
      end
`else
      n_vec++;
      if (n_ack !== 0) begin n_err++; $display("FAIL hw_disabled got %0d acks want 0", n_ack); end
`endif
      bus_read(5'h02);
   endtask

   task automatic test_reset_mid_read();
      bus_write(5'h03, 32'hA5A50001);
      bus_read(5'h03);
      @(posedge clk); #1;
      avs_address = 5'h03; avs_read = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0; avs_read = 1'b0;
      @(negedge clk);
      n_vec++;
      if (avs_waitrequest !== 1'b0) begin n_err++; $display("FAIL rstrd_in_rd got wait=%b want 0", avs_waitrequest); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({avs_waitrequest, avs_readdatavalid, hw_bit_ack, csr_d_bit} !== 4'b1000 || avs_readdata !== '0) begin
         n_err++;
         $display("FAIL rstrd_ctl got wr=%b rdv=%b ack=%b dbit=%b rd=%h want 1 0 0 0 0",
                  avs_waitrequest, avs_readdatavalid, hw_bit_ack, csr_d_bit, avs_readdata);
      end
      n_vec++;
      if (csr_load_all_n !== 8'hFF || csr_load_bit_n !== 8'hFF || csr_d_all !== '0 || csr_bit_address !== '0) begin
         n_err++;
         $display("FAIL rstrd_csr got all_n=%h bit_n=%h dall=%h baddr=%0d want ff ff 0 0",
                  csr_load_all_n, csr_load_bit_n, csr_d_all, csr_bit_address);
      end
      @(negedge clk);
      n_vec++;
      if (avs_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rstrd_late_rdv got 1 want 0"); end
      bus_read(5'h03);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_whole_write();
      test_bit_op();
      test_out_of_range();
      test_random();
      test_back_to_back();
      test_write_read_together();
      test_hw_port();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
